fib_seq_engine: RTL and testbench
=================================

// Module: fib_seq_engine
// PURPOSE
//  Parametrised Fibonacci sequence generator peripheral for the Von Neumann processor SoC.
//  Replaces per-cycle A/B register rotation with autonomous sequence generation.
//  Emits N terms from programmable seeds over a valid/ready stream.
//  Flags arithmetic wrap and raises a level interrupt when the run completes.
// PARAMETERS
//  WIDTH   4  term width in bits; all arithmetic is modulo 2^WIDTH
//  CNT_W   4  width of n_terms; max run length 2^CNT_W-1
//  SEED_A  0  reset value of seed register A (first term)
//  SEED_B  1  reset value of seed register B (second term)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      begin run; sampled only in IDLE
//  n_terms    in   CNT_W  terms to emit; sampled with start
//  seed_load  in   1      load seed_a/seed_b into seed regs; IDLE only
//  seed_a     in   WIDTH  first-term seed
//  seed_b     in   WIDTH  second-term seed
//  out_ready  in   1      consumer accepts out_data this cycle
//  out_valid  out  1      out_data holds a term
//  out_data   out  WIDTH  current term
//  out_last   out  1      with out_valid: final term of the run
//  busy       out  1      high in EMIT
//  done       out  1      one-cycle pulse at run end
//  ovf        out  1      sticky: a wrapped term was emitted this run
//  irq        out  1      level interrupt, set at run end
//  irq_ack    in   1      clears irq
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_data=0, out_last=0, busy=0, done=0, ovf=0, irq=0.
//    Seed regs reset to SEED_A/SEED_B. Reset mid-run aborts the run; no done, no irq.
//  FSM states:
//    IDLE -> EMIT on start with n_terms!=0.
//      Loads A<=seedA, B<=seedB, cnt<=n_terms; clears ovf and irq.
//    IDLE -> DONE on start with n_terms==0. No beat is emitted.
//    EMIT -> EMIT on an accepted beat with cnt>1.
//    EMIT -> DONE on an accepted beat with cnt==1.
//    DONE -> IDLE unconditionally. done=1 for exactly this cycle; irq<=1.
//  Latency: start accepted in cycle t -> out_valid=1 in cycle t+1. One term per cycle while out_ready=1.
//  EMIT outputs: out_valid=1, out_data=A, out_last=(cnt==1).
//    A beat is accepted when out_valid && out_ready.
//    On acceptance: A<=B, B<=A+B (WIDTH-bit wrap), cnt<=cnt-1.
//  Backpressure: while out_ready=0, out_data, out_last and all state hold.
//  Wrap tracking:
//    A and B each carry a wrap flag; seeds load with flag 0.
//    New B flag = carry_out(A+B) | A.flag | B.flag.
//    ovf<=1 on any accepted beat whose A.flag=1. Cleared only by start or reset.
//  Ignored inputs:
//    start while busy or in DONE is ignored.
//    seed_load outside IDLE is ignored.
//    seed_load and start in the same IDLE cycle: seed_load first; the run uses the new seeds.
//  irq: set in DONE, cleared by irq_ack or by an accepted start. If set and irq_ack coincide, set wins.
//  n_terms=1: a single beat with out_last=1.
// STRUCTURE
//  Shared include fib_defs.vh:
//    state localparams ST_IDLE=2'd0, ST_EMIT=2'd1, ST_DONE=2'd2.
//    Default WIDTH/CNT_W.
//  Sub-module fib_add_w #(WIDTH):
//    Combinational adder. Inputs {a,a_flag,b,b_flag}; outputs {sum,sum_flag}.
//  Top level holds the FSM, seed regs, A/B regs, counter and irq logic.
// TESTING
//  1. WIDTH=4, default seeds, n=8, ready=1:
//     0,1,1,2,3,5,8,13 on consecutive cycles; out_last on 13; done pulse; irq=1; ovf=0.
//  2. n=10:
//     ...,13,5,2 (21 and 34 wrap); ovf rises on the beat carrying 5; out_last on 2.
//  3. Backpressure: n=4, ready low 3 cycles after the first beat:
//     out_data=1 held stable 3 cycles; sequence 0,1,1,2 intact.
//  4. seed_load a=2 b=3, then n=4: 2,3,5,8. A second run without reload also gives 2,3,5,8.
//  5. n=0: done pulse 1 cycle after start; out_valid never high; irq=1. irq_ack -> irq=0 next cycle.
//  6. Reset asserted during beat 3 of n=8: all outputs 0 next cycle; no done; a fresh start gives 0,1,...

Source files
------------

// File: rtl/fib_seq_engine_pkg.sv
// Shared FSM encodings and default sizing for the Fibonacci sequence engine.
// Imported by the engine top level and by its adder.
package fib_seq_engine_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int FIB_WIDTH_DEF = 4;
    localparam int FIB_CNT_W_DEF = 4;

endpackage

// File: rtl/fib_add_w.sv
// Combinational ripple-carry adder for sequence terms.
// The sum flag accumulates carry-out and the flags of both operands.
module fib_add_w
    import fib_seq_engine_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic             a_flag,
    input  logic [WIDTH-1:0] b,
    input  logic             b_flag,
    output logic [WIDTH-1:0] sum,
    output logic             sum_flag
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    // A term wraps once any ancestor wrapped, even if this sum itself does not carry.
    assign sum_flag = carry[WIDTH] | a_flag | b_flag;

endmodule

// File: rtl/fib_seq_engine.sv
// Fibonacci sequence generator: emits n_terms terms from programmable seeds
// over a valid/ready stream, tracks arithmetic wrap and raises an irq at run end.
module fib_seq_engine
    import fib_seq_engine_pkg::*;
#(
    parameter int               WIDTH  = FIB_WIDTH_DEF,
    parameter int               CNT_W  = FIB_CNT_W_DEF,
    parameter logic [WIDTH-1:0] SEED_A = '0,
    parameter logic [WIDTH-1:0] SEED_B = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             irq,
    input  logic             irq_ack
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] seed_a_q, seed_a_d;
    logic [WIDTH-1:0] seed_b_q, seed_b_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             a_flag_q, a_flag_d;
    logic             b_flag_q, b_flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sum;
    logic             sum_flag;

    fib_add_w #(.WIDTH(WIDTH)) u_add (
        .a        (a_q),
        .a_flag   (a_flag_q),
        .b        (b_q),
        .b_flag   (b_flag_q),
        .sum      (sum),
        .sum_flag (sum_flag)
    );

    always_comb begin
        state_d  = state_q;
        seed_a_d = seed_a_q;
        seed_b_d = seed_b_q;
        a_d      = a_q;
        b_d      = b_q;
        a_flag_d = a_flag_q;
        b_flag_d = b_flag_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        irq_d    = irq_q;

        case (state_q)
            ST_IDLE: begin
                // Seed update is applied first so a same-cycle start runs on the new seeds.
                if (seed_load) begin
                    seed_a_d = seed_a;
                    seed_b_d = seed_b;
                end
                if (start) begin
                    a_d      = seed_a_d;
                    b_d      = seed_b_d;
                    a_flag_d = 1'b0;
                    b_flag_d = 1'b0;
                    cnt_d    = n_terms;
                    ovf_d    = 1'b0;
                    irq_d    = 1'b0;
                    state_d  = (n_terms != '0) ? ST_EMIT : ST_DONE;
                end else if (irq_ack) begin
                    irq_d = 1'b0;
                end
            end
            ST_EMIT: begin
                if (irq_ack) begin
                    irq_d = 1'b0;
                end
                if (out_ready) begin
                    a_d      = b_q;
                    a_flag_d = b_flag_q;
                    b_d      = sum;
                    b_flag_d = sum_flag;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (a_flag_q) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                irq_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            seed_a_q <= SEED_A;
            seed_b_q <= SEED_B;
            a_q      <= '0;
            b_q      <= '0;
            a_flag_q <= 1'b0;
            b_flag_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_a_q <= seed_a_d;
            seed_b_q <= seed_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_flag_q <= a_flag_d;
            b_flag_q <= b_flag_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = a_q;
    assign out_last  = out_valid && (cnt_q == CNT_W'(1));
    assign busy      = out_valid;
    assign done      = (state_q == ST_DONE);
    assign ovf       = ovf_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: a queue-based reference model checked every cycle,
// directed scenarios pinned by literal sequences, then randomized traffic.
module tb_fib_seq_engine;

    localparam int W  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, start, seed_load, out_ready, irq_ack;
    logic [CW-1:0] n_terms;
    logic [W-1:0]  seed_a, seed_b;
    logic          out_valid, out_last, busy, done, ovf, irq;
    logic [W-1:0]  out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_seq_engine #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_terms   (n_terms),
        .seed_load (seed_load),
        .seed_a    (seed_a),
        .seed_b    (seed_b),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .irq       (irq),
        .irq_ack   (irq_ack)
    );

    // Reference model: pending beats hold the unbounded Fibonacci value;
    // a beat has wrapped exactly when that value no longer fits in W bits.
    typedef struct packed {
        logic [31:0] val;
        logic        wrap;
    } beat_t;

    beat_t        m_q[$];
    bit           m_done = 1'b0;
    bit           m_ovf  = 1'b0;
    bit           m_irq  = 1'b0;
    int unsigned  m_sa   = 0;
    int unsigned  m_sb   = 1;
    bit           chk_en = 1'b0;
    logic [W-1:0] cap[$];

    int exp1[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 0, 0};
    int exp2[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 5, 2};
    int exp3[10] = '{0, 1, 1, 2, 0, 0, 0, 0, 0, 0};
    int exp4[10] = '{2, 3, 5, 8, 0, 0, 0, 0, 0, 0};
    int exp6[10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_run(input int unsigned sa, input int unsigned sb, input int n);
        int unsigned x, y, t;
        x = sa;
        y = sb;
        for (int i = 0; i < n; i++) begin
            m_q.push_back('{val: x, wrap: (x >= (1 << W))});
            t = x + y;
            x = y;
            y = t;
        end
    endtask

    always @(negedge clk) begin
        bit idle;
        bit nd;
        if (chk_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
            chk("busy", {31'd0, busy}, {31'd0, m_q.size() != 0});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
            chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
            if (m_q.size() != 0) begin
                chk("out_data", {28'd0, out_data}, m_q[0].val % (1 << W));
                chk("out_last", {31'd0, out_last}, {31'd0, m_q.size() == 1});
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1 && reset !== 1'b1) begin
            cap.push_back(out_data);
        end
        if (reset) begin
            m_q.delete();
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_irq  = 1'b0;
            m_sa   = 0;
            m_sb   = 1;
            chk_en = 1'b1;
        end else begin
            idle = (m_q.size() == 0) && !m_done;
            if (m_done)              m_irq = 1'b1;
            else if (idle && start)  m_irq = 1'b0;
            else if (irq_ack)        m_irq = 1'b0;
            nd = 1'b0;
            if (m_q.size() != 0) begin
                if (out_ready) begin
                    if (m_q[0].wrap) m_ovf = 1'b1;
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) nd = 1'b1;
                end
            end else if (idle) begin
                if (seed_load) begin
                    m_sa = seed_a;
                    m_sb = seed_b;
                end
                if (start) begin
                    m_ovf = 1'b0;
                    build_run(m_sa, m_sb, int'(n_terms));
                    if (n_terms == 0) nd = 1'b1;
                end
            end
            m_done = nd;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start   = 1'b1;
        n_terms = CW'(n);
        cycle();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            cycle();
            k++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic chk_seq(input string tag, input int e[10], input int n);
        chk({tag, "_len"}, cap.size(), n);
        for (int i = 0; i < n && i < cap.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), {28'd0, cap[i]}, e[i]);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; n_terms = '0; seed_load = 1'b0;
        seed_a = '0; seed_b = '0; out_ready = 1'b1; irq_ack = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_out_data", {28'd0, out_data}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // Default seeds, eight terms, no backpressure.
        cap.delete();
        do_start(8);
        chk("t1_first_valid", {31'd0, out_valid}, 32'd1);
        wait_done("t1", 40);
        chk_seq("t1", exp1, 8);
        cycle();
        chk("t1_irq", {31'd0, irq}, 32'd1);
        chk("t1_ovf", {31'd0, ovf}, 32'd0);

        // Ten terms: 21 and 34 wrap to 5 and 2.
        cap.delete();
        do_start(10);
        wait_done("t2", 40);
        chk_seq("t2", exp2, 10);
        chk("t2_ovf", {31'd0, ovf}, 32'd1);
        cycle();

        // Backpressure after the first beat.
        cap.delete();
        do_start(4);
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_hold%0d", i), {28'd0, out_data}, 32'd1);
            cycle();
        end
        out_ready = 1'b1;
        wait_done("t3", 40);
        chk_seq("t3", exp3, 4);
        cycle();

        // Seed load, then two runs on the same seeds.
        seed_load = 1'b1; seed_a = 4'd2; seed_b = 4'd3;
        cycle();
        seed_load = 1'b0;
        for (int r = 0; r < 2; r++) begin
            cap.delete();
            do_start(4);
            wait_done($sformatf("t4r%0d", r), 40);
            chk_seq($sformatf("t4r%0d", r), exp4, 4);
            cycle();
        end

        // Zero-length run.
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
        do_start(0);
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("t5_irq_set", {31'd0, irq}, 32'd1);
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
        chk("t5_irq_clr", {31'd0, irq}, 32'd0);

        // Reset in the middle of a run.
        do_start(8);
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_data", {28'd0, out_data}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_nodone%0d", i), {31'd0, done}, 32'd0);
            cycle();
        end
        chk("t6_noirq", {31'd0, irq}, 32'd0);
        cap.delete();
        do_start(3);
        wait_done("t6", 40);
        chk_seq("t6", exp6, 3);
        cycle();

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            n_terms   = CW'($urandom_range(0, 15));
            seed_load = ($urandom_range(0, 7) == 0);
            seed_a    = W'($urandom);
            seed_b    = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            irq_ack   = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0; start = 1'b0; seed_load = 1'b0; irq_ack = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
